burst_ram: RTL and testbench

BURST_RAM -- requirements
Module: burst_ram

---
 rtl/burst_ram.sv | 164 ++++++++++++++++
 tb/tb_burst_ram.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram.sv
// Single-port word RAM with burst read/write request handshake.
// Clears itself to zero after every reset before accepting requests.
module burst_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 1 << ADDR_WIDTH,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WRITE,
        READ
    } state_e;

    localparam int CNT_WIDTH = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  busy_q, busy_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [LENGTH];

    logic                  rd_pop;
    logic                  rd_issue;

    always_comb begin
        addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
    end

    // Next array read only when the output register is empty or drains this cycle.
    always_comb begin
        rd_pop   = (state_q == READ) && rd_valid_q && rd_ready;
        rd_issue = (state_q == READ) && (cnt_q != '0) && (!rd_valid_q || rd_ready);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;
        mem_wdata  = wr_data;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                addr_d    = addr_inc;
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    cnt_d   = CNT_WIDTH'(req_len) + CNT_ONE;
                    state_d = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid && wr_ready_q) begin
                    mem_we = 1'b1;
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    rd_data_d  = mem[addr_q];
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == CNT_ONE);
                    addr_d     = addr_inc;
                    cnt_d      = cnt_q - CNT_ONE;
                end else if (rd_pop) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end
                if (rd_pop && rd_last_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            addr_q      <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Writes are suppressed on a reset edge so an aborted burst leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[addr_q] <= mem_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: randomized bursts against a word-array model.
module tb_burst_ram;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LW  = 4;
    localparam int LEN = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [LW-1:0] req_len   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          wr_valid  = 1'b0;
    logic          rd_ready  = 1'b0;
    logic          req_ready;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          busy;

    burst_ram #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LENGTH    (LEN),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_len  (req_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_last  (rd_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         got_q[$];
    logic [DW-1:0] mem_m   [LEN];
    logic [DW-1:0] wbuf    [16];
    logic [DW-1:0] exp_lit [16];

    int            checks     = 0;
    int            errors     = 0;
    bit            chk_en     = 1'b0;
    bit            wr_phase   = 1'b0;
    bit            rd_phase   = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    beat_t         cur;
    int            cyc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the transaction-level model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_vs_ready", 32'(busy), 32'(!req_ready));
            chk("wr_ready_window", 32'(wr_ready), 32'(wr_phase));
            if (wr_phase || rd_phase) chk("req_ready_in_burst", 32'(req_ready), 32'(0));
            if (prev_stall) begin
                chk("rd_hold_valid", 32'(rd_valid), 32'(1));
                chk("rd_hold_data", 32'(rd_data), 32'(prev_data));
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected_beat", 32'(rd_valid), 32'(0));
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(exp_q[0].data));
                    chk("rd_last", 32'(rd_last), 32'(exp_q[0].last));
                    if (rd_ready) begin
                        cur.data = rd_data;
                        cur.last = rd_last;
                        got_q.push_back(cur);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    task automatic do_reset(input int hold);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        req_valid  = 1'b0;
        wr_valid   = 1'b0;
        rd_ready   = 1'b0;
        wr_phase   = 1'b0;
        rd_phase   = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_rd_last", 32'(rd_last), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        for (int i = 0; i < LEN; i++) mem_m[i] = '0;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_init();
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n <= 100) begin
            @(negedge clk);
            if (busy !== 1'b1) done = 1'b1;
            else n++;
        end
        chk("init_busy_cycles", 32'(n), 32'(16));
        chk("ready_after_init", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic w, input int addr, input int len);
        bit acc = 1'b0;
        int t   = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = AW'(addr);
        req_len   = LW'(len);
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = (req_ready === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = 1'b0;
        if (!acc) chk("req_accept_timeout", 32'(acc), 32'(1));
    endtask

    task automatic do_write(input int addr, input int len, input int gap_before, input bit rnd);
        int a        = addr;
        int i        = 0;
        int t        = 0;
        bit gap_done = 1'b0;
        bit v;
        send_req(1'b1, addr, len);
        wr_phase = 1'b1;
        while (i <= len && t < 400) begin
            if (rnd) v = ($urandom_range(0, 9) < 7);
            else if (i == gap_before && !gap_done) begin
                v        = 1'b0;
                gap_done = 1'b1;
            end else v = 1'b1;
            wr_valid = v;
            wr_data  = v ? wbuf[i] : 8'hEE;
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                mem_m[a] = wbuf[i];
                a        = (a + 1) % LEN;
                i++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        wr_valid = 1'b0;
        wr_phase = 1'b0;
        if (i != len + 1) chk("write_beats_timeout", 32'(i), 32'(len + 1));
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic do_read(input int addr, input int len, input int mode, output int cycles);
        beat_t b;
        int    t = 0;
        send_req(1'b0, addr, len);
        for (int i = 0; i <= len; i++) begin
            b.data = mem_m[(addr + i) % LEN];
            b.last = (i == len);
            exp_q.push_back(b);
        end
        rd_phase = 1'b1;
        while (exp_q.size() != 0 && t < 400) begin
            if (mode == 0) rd_ready = 1'b1;
            else if (mode == 1) rd_ready = (t % 3 == 0);
            else rd_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            t++;
        end
        rd_ready = 1'b0;
        rd_phase = 1'b0;
        if (exp_q.size() != 0) chk("read_drain_timeout", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        cycles = t;
    endtask

    task automatic check_got(input string name, input int n);
        chk({name, "_count"}, 32'(got_q.size()), 32'(n));
        if (got_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({name, "_data"}, 32'(got_q[i].data), 32'(exp_lit[i]));
                chk({name, "_last"}, 32'(got_q[i].last), 32'(i == n - 1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        wait_init();

        for (int a = 0; a < LEN; a++) begin
            got_q.delete();
            do_read(a, 0, 0, cyc);
            exp_lit[0] = 8'h00;
            check_got("init_zero", 1);
        end

        wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
        do_write(3, 3, 2, 1'b0);
        got_q.delete();
        do_read(3, 3, 0, cyc);
        exp_lit[0] = 8'hA1; exp_lit[1] = 8'hA2; exp_lit[2] = 8'hA3; exp_lit[3] = 8'hA4;
        check_got("gap_write", 4);

        wbuf[0] = 8'hB1; wbuf[1] = 8'hB2; wbuf[2] = 8'hB3; wbuf[3] = 8'hB4;
        do_write(14, 3, -1, 1'b0);
        got_q.delete();
        do_read(14, 3, 0, cyc);
        exp_lit[0] = 8'hB1; exp_lit[1] = 8'hB2; exp_lit[2] = 8'hB3; exp_lit[3] = 8'hB4;
        check_got("wrap_rw", 4);
        got_q.delete();
        do_read(0, 0, 0, cyc);
        exp_lit[0] = 8'hB3;
        check_got("wrap_addr0", 1);

        got_q.delete();
        do_read(3, 3, 1, cyc);
        exp_lit[0] = 8'hA1; exp_lit[1] = 8'hA2; exp_lit[2] = 8'hA3; exp_lit[3] = 8'hA4;
        check_got("stall_read", 4);

        for (int i = 0; i < 16; i++) wbuf[i] = 8'(8'h40 + i);
        do_write(5, 15, -1, 1'b0);
        got_q.delete();
        do_read(5, 15, 0, cyc);
        for (int i = 0; i < 16; i++) exp_lit[i] = 8'(8'h40 + i);
        check_got("max_burst", 16);
        chk("max_burst_cycles", 32'(cyc), 32'(17));

        for (int n = 0; n < 40; n++) begin
            int a = $urandom_range(0, LEN - 1);
            int l = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom_range(0, 255));
                do_write(a, l, -1, 1'b1);
            end else begin
                do_read(a, l, 2, cyc);
            end
        end

        wbuf[0] = 8'h5A;
        do_write(2, 0, -1, 1'b0);
        do_read(2, 0, 0, cyc);

        send_req(1'b1, 8, 3);
        wr_phase = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hC1;
        @(posedge clk);
        #1;
        wr_data = 8'hC2;
        do_reset(1);
        got_q.delete();
        fork
            wait_init();
            do_read(8, 3, 0, cyc);
        join
        for (int i = 0; i < 4; i++) exp_lit[i] = 8'h00;
        check_got("abort_cleared", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
